// File: rtl/neural_layer_engine.sv
// Fully-connected layer engine: signed fixed-point MAC over internal neuron/weight RAMs.
// Define NEURAL_ENGINE_RELU_EN to clamp negative results to zero before write-back.
module neural_layer_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int WADDR_W   = 10,
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  in_base,
    input  logic [ADDR_W-1:0]  in_count,
    input  logic [ADDR_W-1:0]  out_base,
    input  logic [ADDR_W-1:0]  out_count,
    input  logic [WADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0]  neuron_ram_write_adr_ext,
    input  logic [DATA_W-1:0]  neuron_ram_write_data_ext,
    input  logic               neuron_ram_wr_en_ext,
    input  logic [ADDR_W-1:0]  neuron_ram_read_adr_ext,
    output logic [DATA_W-1:0]  neuron_ram_read_data_ext,
    input  logic [WADDR_W-1:0] weight_ram_write_adr_ext,
    input  logic [DATA_W-1:0]  weight_ram_write_data_ext,
    input  logic               weight_ram_wr_en_ext,
    output logic               busy,
    output logic               finished,
    output logic [ADDR_W-1:0]  result_base_address,
    output logic [ADDR_W-1:0]  result_word_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE, S_DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (DATA_W-1)));

    state_t state_q, state_d;

    logic [DATA_W-1:0] neuron_ram [2**ADDR_W];
    logic [DATA_W-1:0] weight_ram [2**WADDR_W];

    logic [ADDR_W-1:0]  in_base_q, in_cnt_q, out_base_q, out_cnt_q;
    logic [ADDR_W-1:0]  i_q, j_q;
    logic [WADDR_W-1:0] wptr_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [DATA_W-1:0]   eng_n_q, eng_w_q;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, shifted;
    logic [DATA_W-1:0]  result;
    logic [ADDR_W-1:0]  n_rd_adr;
    logic [WADDR_W-1:0] w_rd_adr;
    logic               idle_w, start_ok, rd_step;

    assign idle_w   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_ok = start && idle_w;
    assign busy     = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_WRITE);
    assign finished = (state_q == S_DONE);

    // During MAC the operands for element i are already in flight, so fetch element i+1.
    assign rd_step  = (state_q == S_MAC);
    assign n_rd_adr = in_base_q + i_q + ADDR_W'(rd_step);
    assign w_rd_adr = wptr_q + WADDR_W'(rd_step);

    assign prod     = eng_n_q * eng_w_q;
    assign prod_ext = prod;
    assign shifted  = acc_q >>> FRAC_BITS;

    always_comb begin
        result = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX)
            result = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN)
            result = SAT_MIN[DATA_W-1:0];
`ifdef NEURAL_ENGINE_RELU_EN
        if (result[DATA_W-1])
            result = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE:
                if (start)
                    state_d = (out_count == '0) ? S_DONE : S_LOAD;
            S_LOAD:
                state_d = (in_cnt_q == '0) ? S_WRITE : S_MAC;
            S_MAC:
                if (i_q == in_cnt_q - ADDR_W'(1))
                    state_d = S_WRITE;
            S_WRITE:
                state_d = (j_q == out_cnt_q - ADDR_W'(1)) ? S_DONE : S_LOAD;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_base_q                <= '0;
            in_cnt_q                 <= '0;
            out_base_q               <= '0;
            out_cnt_q                <= '0;
            i_q                      <= '0;
            j_q                      <= '0;
            wptr_q                   <= '0;
            acc_q                    <= '0;
            result_base_address      <= '0;
            result_word_count        <= '0;
            neuron_ram_read_data_ext <= '0;
        end else begin
            neuron_ram_read_data_ext <= neuron_ram[neuron_ram_read_adr_ext];
            if (start_ok) begin
                in_base_q           <= in_base;
                in_cnt_q            <= in_count;
                out_base_q          <= out_base;
                out_cnt_q           <= out_count;
                wptr_q              <= weight_base;
                i_q                 <= '0;
                j_q                 <= '0;
                result_base_address <= out_base;
                result_word_count   <= out_count;
            end
            case (state_q)
                S_LOAD:  acc_q <= '0;
                S_MAC: begin
                    acc_q  <= acc_q + prod_ext;
                    i_q    <= i_q + ADDR_W'(1);
                    wptr_q <= wptr_q + WADDR_W'(1);
                end
                S_WRITE: begin
                    i_q <= '0;
                    j_q <= j_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        eng_n_q <= neuron_ram[n_rd_adr];
        eng_w_q <= weight_ram[w_rd_adr];
        if (state_q == S_WRITE)
            neuron_ram[out_base_q + j_q] <= result;
        else if (neuron_ram_wr_en_ext && idle_w)
            neuron_ram[neuron_ram_write_adr_ext] <= neuron_ram_write_data_ext;
        if (weight_ram_wr_en_ext && idle_w)
            weight_ram[weight_ram_write_adr_ext] <= weight_ram_write_data_ext;
    end

endmodule
